ad_ip_jesd204_tpl_regmap_hub: RTL and testbench
===============================================

// Module: ad_ip_jesd204_tpl_regmap_hub
// PURPOSE
//  Parametrised up-bus hub between one up_axi master port and NUM_SLAVES register sub-blocks.
//  Sub-blocks are up_dac_common, up_dac_channel, up_adc_channel and up_tpl_common.
//  Replaces fixed OR-reduction glue with two independent read and write engines.
//  Each engine registers the request, broadcasts it to the sub-blocks, and collects their
//  ack/data. Missing acks time out; more than one ack for the same request is flagged.
//  Sits inside the ADC and DAC TPL regmaps; NUM_SLAVES is typically NUM_CHANNELS+2.
// PARAMETERS
//  NUM_SLAVES      4     number of sub-blocks (1..64)
//  ADDR_WIDTH      11    up-bus word address width
//  TIMEOUT_CYCLES  32    cycles a request may wait for an ack (2..255)
//  LOCAL_ADDR      'h7FF hub status register address (used only with macro)
// PORTS
//  up_clk      in   1              up-bus clock
//  up_rstn     in   1              async active-low reset
//  up_wreq     in   1              master write request (1-cycle pulse)
//  up_waddr    in   ADDR_WIDTH     master write address
//  up_wdata    in   32             master write data
//  up_wack     out  1              write ack to master (1-cycle pulse)
//  up_rreq     in   1              master read request (1-cycle pulse)
//  up_raddr    in   ADDR_WIDTH     master read address
//  up_rdata    out  32             read data, valid with up_rack
//  up_rack     out  1              read ack to master (1-cycle pulse)
//  s_wreq      out  1              write request broadcast to all sub-blocks
//  s_waddr     out  ADDR_WIDTH     write address broadcast
//  s_wdata     out  32             write data broadcast
//  s_wack      in   NUM_SLAVES     per-sub-block write ack
//  s_rreq      out  1              read request broadcast to all sub-blocks
//  s_raddr     out  ADDR_WIDTH     read address broadcast
//  s_rdata     in   NUM_SLAVES*32  per-sub-block read data; 0 when the sub-block is not addressed
//  s_rack      in   NUM_SLAVES     per-sub-block read ack
//  up_err      out  1              1-cycle pulse on timeout or multi-ack, either engine
// BEHAVIOUR
//  Reset: all outputs 0, both FSMs IDLE, counters 0. Reset mid-transaction aborts it; no ack issued.
//  Each engine has its own FSM: IDLE -> WAIT -> RESP -> IDLE.
//   IDLE: on req, latch addr/data and go to WAIT. s_*req is high for exactly the first WAIT cycle.
//   WAIT: each cycle, OR all s_*ack bits; for read, OR all s_rdata words.
//    - Any ack seen: register the OR'd data and go to RESP.
//    - More than one ack bit set in that same cycle: still go to RESP; pulse up_err.
//    - No ack after TIMEOUT_CYCLES WAIT cycles: go to RESP; up_rdata=32'hDEAD_DEAD; pulse up_err.
//   RESP: up_*ack=1 for one cycle; up_rdata holds the registered data. Next state IDLE.
//  Latency: sub-block acks k cycles after s_*req (k>=0).
//   up_*ack rises k+2 cycles after the master req.
//  The WAIT cycle counter is 8 bits and saturates; it never wraps.
//  Acks arriving in IDLE or RESP (late, after a timeout) are ignored silently.
//  A master req while the engine is not IDLE is dropped; up_axi never issues one.
//  Read and write engines may be active at the same time without interaction.
//  up_rdata is 0 outside RESP, so it can be OR-combined upstream.
//  up_err is the registered OR of both engines' error events.
// CONFIGURATION
//  REGMAP_HUB_ERR_STATUS_EN defined: the hub owns register LOCAL_ADDR.
//   - Access to LOCAL_ADDR is not broadcast. The hub acks it 2 cycles after req.
//   - Read returns {timeout_cnt[15:0], multiack_cnt[15:0]}; counters saturate at 'hFFFF.
//   - Any write to LOCAL_ADDR clears both counters.
//   - A clear in the same cycle as an error event wins: counter reads 0.
//  Not defined: no counters or local register. LOCAL_ADDR is broadcast like any other address.
// TESTING
//  - Read, sub-block 2 acks at k=1 with 'h1234_5678 -> up_rack 3 cycles after up_rreq,
//    up_rdata='h1234_5678, up_err stays 0.
//  - Write, no sub-block acks -> up_wack exactly TIMEOUT_CYCLES+1 cycles after up_wreq;
//    up_err pulses once. A late s_wack afterwards produces no second ack.
//  - Read, sub-blocks 0 and 3 ack in the same cycle with 'h00F0/'h0F00 -> up_rdata='h0FF0, up_err pulse.
//  - Concurrent up_wreq and up_rreq, acks at different k -> each ack at its own k+2;
//    data is not mixed between engines.
//  - up_rstn low during WAIT -> no ack emitted, all outputs 0. The next request completes normally.
//  - With REGMAP_HUB_ERR_STATUS_EN: 3 timeouts then read LOCAL_ADDR -> 'h0003_0000;
//    write LOCAL_ADDR, read again -> 0; s_rreq never asserted for these accesses.

Source files
------------

// File: rtl/ad_ip_jesd204_tpl_regmap_hub.sv
// Up-bus hub: broadcasts master accesses to NUM_SLAVES sub-blocks and merges acks/data (REGMAP_HUB_ERR_STATUS_EN adds a local error-status register).
// Latency: up_*ack k+2 cycles after req for a sub-block ack k cycles after s_*req; TIMEOUT_CYCLES+1 on timeout; 2 for the local register.
// Backpressure: none; one outstanding access per engine, requests arriving while an engine is busy are dropped.
module ad_ip_jesd204_tpl_regmap_hub #(
    parameter int NUM_SLAVES     = 4,
    parameter int ADDR_WIDTH     = 11,
    parameter int TIMEOUT_CYCLES = 32,
    parameter int LOCAL_ADDR     = 'h7FF
) (
    input  logic                       up_clk,
    input  logic                       up_rstn,
    input  logic                       up_wreq,
    input  logic [ADDR_WIDTH-1:0]      up_waddr,
    input  logic [31:0]                up_wdata,
    output logic                       up_wack,
    input  logic                       up_rreq,
    input  logic [ADDR_WIDTH-1:0]      up_raddr,
    output logic [31:0]                up_rdata,
    output logic                       up_rack,
    output logic                       s_wreq,
    output logic [ADDR_WIDTH-1:0]      s_waddr,
    output logic [31:0]                s_wdata,
    input  logic [NUM_SLAVES-1:0]      s_wack,
    output logic                       s_rreq,
    output logic [ADDR_WIDTH-1:0]      s_raddr,
    input  logic [NUM_SLAVES*32-1:0]   s_rdata,
    input  logic [NUM_SLAVES-1:0]      s_rack,
    output logic                       up_err
);

    if (NUM_SLAVES < 1 || NUM_SLAVES > 64 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255 ||
        LOCAL_ADDR < 0 || LOCAL_ADDR >= (1 << ADDR_WIDTH)) begin : g_bad_params
        $error("ad_ip_jesd204_tpl_regmap_hub: parameter out of range");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_LOCL, ST_RESP} state_t;

    localparam logic [7:0]            CNT_LAST     = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [NUM_SLAVES-1:0] ONE          = NUM_SLAVES'(1);
    localparam logic [31:0]           TIMEOUT_DATA = 32'hDEAD_DEAD;

    state_t      w_state, w_state_nxt;
    state_t      r_state, r_state_nxt;
    logic [7:0]  w_cnt, r_cnt;
    logic        w_local, r_local;
    logic        w_any, w_multi, r_any, r_multi;
    logic        w_timeout, w_multiack, r_timeout, r_multiack;
    logic [31:0] r_or_data;
    logic [31:0] r_resp_data;
    logic [31:0] status_data;

    // x & (x-1) clears the lowest set bit; anything left means two or more acks
    assign w_any   = |s_wack;
    assign w_multi = |(s_wack & (s_wack - ONE));
    assign r_any   = |s_rack;
    assign r_multi = |(s_rack & (s_rack - ONE));

    always_comb begin
        r_or_data = 32'd0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            r_or_data = r_or_data | s_rdata[i*32 +: 32];
        end
    end

`ifdef REGMAP_HUB_ERR_STATUS_EN
    localparam logic [ADDR_WIDTH-1:0] LOCAL_A = ADDR_WIDTH'(LOCAL_ADDR);

    logic [15:0] timeout_cnt, multiack_cnt;
    logic        cnt_clr;

    function automatic logic [15:0] sat_add(input logic [15:0] v, input logic [1:0] inc);
        logic [16:0] s;
        s = {1'b0, v} + {15'd0, inc};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    assign w_local     = (up_waddr == LOCAL_A);
    assign r_local     = (up_raddr == LOCAL_A);
    assign status_data = {timeout_cnt, multiack_cnt};
    // a local write clears in the cycle before its ack; the clear beats any concurrent error
    assign cnt_clr     = (w_state == ST_LOCL);

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            timeout_cnt  <= 16'd0;
            multiack_cnt <= 16'd0;
        end else if (cnt_clr) begin
            timeout_cnt  <= 16'd0;
            multiack_cnt <= 16'd0;
        end else begin
            timeout_cnt  <= sat_add(timeout_cnt, {1'b0, w_timeout} + {1'b0, r_timeout});
            multiack_cnt <= sat_add(multiack_cnt, {1'b0, w_multiack} + {1'b0, r_multiack});
        end
    end
`else
    assign w_local     = 1'b0;
    assign r_local     = 1'b0;
    assign status_data = 32'd0;
`endif

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            w_state <= ST_IDLE;
            r_state <= ST_IDLE;
        end else begin
            w_state <= w_state_nxt;
            r_state <= r_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = w_state;
        w_timeout   = 1'b0;
        w_multiack  = 1'b0;
        case (w_state)
            ST_IDLE: if (up_wreq) w_state_nxt = w_local ? ST_LOCL : ST_WAIT;
            ST_WAIT: begin
                if (w_any) begin
                    w_state_nxt = ST_RESP;
                    w_multiack  = w_multi;
                end else if (w_cnt >= CNT_LAST) begin
                    w_state_nxt = ST_RESP;
                    w_timeout   = 1'b1;
                end
            end
            ST_LOCL: w_state_nxt = ST_RESP;
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        r_state_nxt = r_state;
        r_timeout   = 1'b0;
        r_multiack  = 1'b0;
        r_resp_data = 32'd0;
        case (r_state)
            ST_IDLE: if (up_rreq) r_state_nxt = r_local ? ST_LOCL : ST_WAIT;
            ST_WAIT: begin
                if (r_any) begin
                    r_state_nxt = ST_RESP;
                    r_multiack  = r_multi;
                    r_resp_data = r_or_data;
                end else if (r_cnt >= CNT_LAST) begin
                    r_state_nxt = ST_RESP;
                    r_timeout   = 1'b1;
                    r_resp_data = TIMEOUT_DATA;
                end
            end
            ST_LOCL: begin
                r_state_nxt = ST_RESP;
                r_resp_data = status_data;
            end
            ST_RESP: r_state_nxt = ST_IDLE;
            default: r_state_nxt = ST_IDLE;
        endcase
    end

    // WAIT-cycle counters restart on every entry to WAIT and stick at 8'hFF
    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            w_cnt <= 8'd0;
            r_cnt <= 8'd0;
        end else begin
            if (w_state != ST_WAIT)   w_cnt <= 8'd0;
            else if (w_cnt != 8'hFF)  w_cnt <= w_cnt + 8'd1;
            if (r_state != ST_WAIT)   r_cnt <= 8'd0;
            else if (r_cnt != 8'hFF)  r_cnt <= r_cnt + 8'd1;
        end
    end

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            s_wreq   <= 1'b0;
            s_waddr  <= '0;
            s_wdata  <= 32'd0;
            s_rreq   <= 1'b0;
            s_raddr  <= '0;
            up_rdata <= 32'd0;
            up_err   <= 1'b0;
        end else begin
            s_wreq <= (w_state == ST_IDLE) && up_wreq && !w_local;
            s_rreq <= (r_state == ST_IDLE) && up_rreq && !r_local;
            if ((w_state == ST_IDLE) && up_wreq && !w_local) begin
                s_waddr <= up_waddr;
                s_wdata <= up_wdata;
            end
            if ((r_state == ST_IDLE) && up_rreq && !r_local) begin
                s_raddr <= up_raddr;
            end
            // r_resp_data is zero except on the transition into RESP
            up_rdata <= r_resp_data;
            up_err   <= w_timeout | w_multiack | r_timeout | r_multiack;
        end
    end

    assign up_wack = (w_state == ST_RESP);
    assign up_rack = (r_state == ST_RESP);

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_regmap_hub.sv
// Bench for the up-bus hub: directed and random accesses checked against a cycle-count/OR model.
module tb_ad_ip_jesd204_tpl_regmap_hub;

    localparam int NS = 4;
    localparam int AW = 11;
    localparam int T  = 32;
    localparam logic [AW-1:0] LOC = 11'h7FF;

    logic              up_clk;
    logic              up_rstn;
    logic              up_wreq;
    logic [AW-1:0]     up_waddr;
    logic [31:0]       up_wdata;
    logic              up_wack;
    logic              up_rreq;
    logic [AW-1:0]     up_raddr;
    logic [31:0]       up_rdata;
    logic              up_rack;
    logic              s_wreq;
    logic [AW-1:0]     s_waddr;
    logic [31:0]       s_wdata;
    logic [NS-1:0]     s_wack;
    logic              s_rreq;
    logic [AW-1:0]     s_raddr;
    logic [NS*32-1:0]  s_rdata;
    logic [NS-1:0]     s_rack;
    logic              up_err;

    int checks = 0;
    int failures = 0;
    int to_cnt = 0;
    int ma_cnt = 0;
    logic [31:0] words [NS];

    ad_ip_jesd204_tpl_regmap_hub #(
        .NUM_SLAVES(NS), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(T), .LOCAL_ADDR(int'(LOC))
    ) dut (
        .up_clk(up_clk), .up_rstn(up_rstn),
        .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata), .up_wack(up_wack),
        .up_rreq(up_rreq), .up_raddr(up_raddr), .up_rdata(up_rdata), .up_rack(up_rack),
        .s_wreq(s_wreq), .s_waddr(s_waddr), .s_wdata(s_wdata), .s_wack(s_wack),
        .s_rreq(s_rreq), .s_raddr(s_raddr), .s_rdata(s_rdata), .s_rack(s_rack),
        .up_err(up_err)
    );

    initial up_clk = 1'b0;
    always #5 up_clk = ~up_clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        return AW'($urandom_range(0, int'(LOC) - 1));
    endfunction

    task automatic chk_all_zero(input string tag);
        chk1({tag, "_wack"}, up_wack, 1'b0);
        chk1({tag, "_rack"}, up_rack, 1'b0);
        chk32({tag, "_rdata"}, up_rdata, 32'd0);
        chk1({tag, "_err"}, up_err, 1'b0);
        chk1({tag, "_swreq"}, s_wreq, 1'b0);
        chk1({tag, "_srreq"}, s_rreq, 1'b0);
        chk32({tag, "_swaddr"}, 32'(s_waddr), 32'd0);
        chk32({tag, "_swdata"}, s_wdata, 32'd0);
        chk32({tag, "_sraddr"}, 32'(s_raddr), 32'd0);
    endtask

    // k < 0 means no sub-block answers; wl/rl target the hub's own register
    task automatic run(input bit dw, input int wk, input logic [NS-1:0] wm,
                       input bit dr, input int rk, input logic [NS-1:0] rm,
                       input int late_w, input bit wl, input bit rl);
        logic [AW-1:0]    wa, ra;
        logic [31:0]      wd, rexp;
        logic [NS*32-1:0] rbus;
        int               w_exp, r_exp, last;
        bit               w_e, r_e, w_bc, r_bc;
        wa = wl ? LOC : rnd_addr();
        ra = rl ? LOC : rnd_addr();
        wd = $urandom;
        w_bc  = dw && !wl;
        r_bc  = dr && !rl;
        w_exp = !dw ? -1 : (wl ? 2 : (wk >= 0 ? wk + 2 : T + 1));
        r_exp = !dr ? -1 : (rl ? 2 : (rk >= 0 ? rk + 2 : T + 1));
        w_e   = w_bc && (wk < 0 || $countones(wm) > 1);
        r_e   = r_bc && (rk < 0 || $countones(rm) > 1);
        rbus  = '0;
        rexp  = 32'd0;
        for (int i = 0; i < NS; i++) begin
            if (rm[i]) begin
                rbus[i*32 +: 32] = words[i];
                rexp = rexp | words[i];
            end
        end
        if (rl)          rexp = {to_cnt[15:0], ma_cnt[15:0]};
        else if (rk < 0) rexp = 32'hDEAD_DEAD;
        last = (w_exp > r_exp) ? w_exp : r_exp;
        if (late_w > last) last = late_w;
        last = last + 3;

        @(negedge up_clk);
        up_wreq = dw; up_waddr = wa; up_wdata = wd;
        up_rreq = dr; up_raddr = ra;
        for (int n = 1; n <= last; n++) begin
            @(negedge up_clk);
            chk1($sformatf("wack@%0d", n), up_wack, 1'(n == w_exp));
            chk1($sformatf("rack@%0d", n), up_rack, 1'(n == r_exp));
            chk32($sformatf("rdata@%0d", n), up_rdata, (n == r_exp) ? rexp : 32'd0);
            chk1($sformatf("err@%0d", n), up_err, 1'((n == w_exp && w_e) || (n == r_exp && r_e)));
            chk1($sformatf("swreq@%0d", n), s_wreq, 1'(w_bc && n == 1));
            chk1($sformatf("srreq@%0d", n), s_rreq, 1'(r_bc && n == 1));
            if (n == 1 && w_bc) begin
                chk32("swaddr", 32'(s_waddr), 32'(wa));
                chk32("swdata", s_wdata, wd);
            end
            if (n == 1 && r_bc) chk32("sraddr", 32'(s_raddr), 32'(ra));
            up_wreq = 1'b0;
            up_rreq = 1'b0;
            s_wack  = (w_bc && n == wk + 1) ? wm : '0;
            if (n == late_w) s_wack = s_wack | NS'(1);
            s_rack  = (r_bc && n == rk + 1) ? rm : '0;
            s_rdata = (r_bc && n == rk + 1) ? rbus : '0;
        end
        s_wack = '0; s_rack = '0; s_rdata = '0;

        if (dw && wl) begin to_cnt = 0; ma_cnt = 0; end
        if (w_bc && wk < 0) to_cnt++;
        if (r_bc && rk < 0) to_cnt++;
        if (w_bc && wk >= 0 && $countones(wm) > 1) ma_cnt++;
        if (r_bc && rk >= 0 && $countones(rm) > 1) ma_cnt++;
        if (to_cnt > 65535) to_cnt = 65535;
        if (ma_cnt > 65535) ma_cnt = 65535;
    endtask

    initial begin
        bit            dw, dr;
        int            wk, rk;
        logic [NS-1:0] wm, rm;
        logic [AW-1:0] a;

        up_rstn = 1'b0; up_wreq = 1'b0; up_waddr = '0; up_wdata = 32'd0;
        up_rreq = 1'b0; up_raddr = '0; s_wack = '0; s_rack = '0; s_rdata = '0;
        for (int i = 0; i < NS; i++) words[i] = 32'd0;
        repeat (2) @(negedge up_clk);
        chk_all_zero("rst");
        up_rstn = 1'b1;
        @(negedge up_clk);
        chk_all_zero("idle");

        // single sub-block, k=1
        words[2] = 32'h1234_5678;
        run(0, 0, '0, 1, 1, 4'b0100, 0, 0, 0);

        // write timeout followed by a stray late ack
        run(1, -1, '0, 0, 0, '0, T + 3, 0, 0);

        // two sub-blocks ack together
        words[0] = 32'h0000_00F0;
        words[3] = 32'h0000_0F00;
        run(0, 0, '0, 1, 2, 4'b1001, 0, 0, 0);

        // both engines busy with different k
        for (int i = 0; i < NS; i++) words[i] = $urandom;
        run(1, 0, 4'b0010, 1, 3, 4'b1000, 0, 0, 0);
        run(1, 4, 4'b0001, 1, 0, 4'b0100, 0, 0, 0);

        for (int it = 0; it < 10; it++) begin
            dw = 1'($urandom_range(0, 1));
            dr = 1'($urandom_range(0, 1));
            if (!dw && !dr) dr = 1'b1;
            wk = $urandom_range(0, 6); if (wk == 6) wk = -1;
            rk = $urandom_range(0, 6); if (rk == 6) rk = -1;
            wm = NS'($urandom_range(1, (1 << NS) - 1));
            rm = NS'($urandom_range(1, (1 << NS) - 1));
            for (int i = 0; i < NS; i++) words[i] = $urandom;
            run(dw, wk, wm, dr, rk, rm, 0, 0, 0);
        end

        // reset while both engines wait: nothing may come out afterwards
        @(negedge up_clk);
        a = rnd_addr();
        up_wreq = 1'b1; up_waddr = a; up_wdata = $urandom;
        up_rreq = 1'b1; up_raddr = a;
        @(negedge up_clk);
        up_wreq = 1'b0; up_rreq = 1'b0;
        chk1("pre_rst_swreq", s_wreq, 1'b1);
        repeat (3) @(negedge up_clk);
        up_rstn = 1'b0;
        #1;
        chk_all_zero("midrst");
        to_cnt = 0; ma_cnt = 0;
        @(negedge up_clk);
        up_rstn = 1'b1;
        for (int n = 0; n < T + 3; n++) begin
            @(negedge up_clk);
            chk1("post_rst_wack", up_wack, 1'b0);
            chk1("post_rst_rack", up_rack, 1'b0);
            chk1("post_rst_err", up_err, 1'b0);
        end
        words[1] = $urandom;
        run(1, 2, 4'b0001, 1, 1, 4'b0010, 0, 0, 0);

`ifdef REGMAP_HUB_ERR_STATUS_EN
        run(1, -1, '0, 0, 0, '0, 0, 1, 0);
        repeat (3) run(1, -1, '0, 0, 0, '0, 0, 0, 0);
        chk32("model_status", {to_cnt[15:0], ma_cnt[15:0]}, 32'h0003_0000);
        run(0, 0, '0, 1, 0, '0, 0, 0, 1);
        run(1, -1, '0, 0, 0, '0, 0, 1, 0);
        run(0, 0, '0, 1, 0, '0, 0, 0, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
